// File: rtl/abs_diff_sad_acc.sv
// Streaming absolute-difference unit with a block-wise SAD accumulator.
// A finished block result is held (input stalled) until the consumer takes it.
module abs_diff_sad_acc #(
    parameter int WIDTH     = 8,
    parameter int BLOCK_LEN = 16,
    parameter int SIGNED    = 0,
    parameter int SUM_W     = WIDTH + $clog2(BLOCK_LEN),
    parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] reff,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] diff_out,
    output logic             diff_valid,
    output logic [SUM_W-1:0] sad_out,
    output logic             sad_valid,
    input  logic             sad_ready,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_diff;
    logic             r_diff_valid;
    logic [SUM_W-1:0] r_sad;
    logic             r_sad_valid;
    logic [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_diff;
    logic [SUM_W-1:0] w_acc_sum;

    // One extra bit holds any difference of two WIDTH-bit operands, signed or not.
    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic signed [WIDTH:0] ea;
        logic signed [WIDTH:0] eb;
        logic signed [WIDTH:0] d;
        logic signed [WIDTH:0] nd;
        ea = {(SIGNED != 0) & a[WIDTH-1], a};
        eb = {(SIGNED != 0) & b[WIDTH-1], b};
        d  = ea - eb;
        nd = -d;
        return d[WIDTH] ? nd[WIDTH-1:0] : d[WIDTH-1:0];
    endfunction

    assign w_accept  = in_valid && r_in_ready && !clear;
    assign w_last    = (r_cnt == CNT_W'(BLOCK_LEN - 1));
    assign w_diff    = abs_diff(reff, data);
    assign w_acc_sum = r_acc + SUM_W'(w_diff);

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ACCUM;
        end else begin
            case (r_state)
                ACCUM:   if (w_accept && w_last) w_state_nxt = HOLD;
                HOLD:    if (sad_ready) w_state_nxt = ACCUM;
                default: w_state_nxt = ACCUM;
            endcase
        end
    end

    // in_ready is registered from the next state, so sad_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ACCUM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff       <= '0;
            r_diff_valid <= 1'b0;
            r_sad        <= '0;
            r_sad_valid  <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
        end else if (clear) begin
            r_diff_valid <= 1'b0;
            r_sad_valid  <= 1'b0;
            r_acc        <= '0;
            r_cnt        <= '0;
        end else begin
            r_diff_valid <= w_accept;
            if (w_accept) begin
                r_diff <= w_diff;
                if (w_last) begin
                    r_sad       <= w_acc_sum;
                    r_sad_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (r_state == HOLD && sad_ready) begin
                r_sad_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign diff_out   = r_diff;
    assign diff_valid = r_diff_valid;
    assign sad_out    = r_sad;
    assign sad_valid  = r_sad_valid;
    assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_abs_diff_sad_acc.sv
// Directed bench for abs_diff_sad_acc: three instances cover unsigned/4, signed/4 and unsigned/5.
module tb_abs_diff_sad_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       sad_ready;
    logic [7:0] reff;
    logic [7:0] data;
    logic       v0, v1, v2;

    logic [7:0]  a0_diff, a1_diff, a2_diff;
    logic        a0_dv, a1_dv, a2_dv;
    logic        a0_rdy, a1_rdy, a2_rdy;
    logic        a0_sv, a1_sv, a2_sv;
    logic [9:0]  a0_sad, a1_sad;
    logic [10:0] a2_sad;
    logic [1:0]  a0_cnt, a1_cnt;
    logic [2:0]  a2_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    abs_diff_sad_acc #(.WIDTH(8), .BLOCK_LEN(4), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v0), .in_ready(a0_rdy),
        .reff(reff), .data(data), .diff_out(a0_diff), .diff_valid(a0_dv),
        .sad_out(a0_sad), .sad_valid(a0_sv), .sad_ready(sad_ready), .sample_cnt(a0_cnt)
    );

    abs_diff_sad_acc #(.WIDTH(8), .BLOCK_LEN(4), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v1), .in_ready(a1_rdy),
        .reff(reff), .data(data), .diff_out(a1_diff), .diff_valid(a1_dv),
        .sad_out(a1_sad), .sad_valid(a1_sv), .sad_ready(sad_ready), .sample_cnt(a1_cnt)
    );

    abs_diff_sad_acc #(.WIDTH(8), .BLOCK_LEN(5), .SIGNED(0)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v2), .in_ready(a2_rdy),
        .reff(reff), .data(data), .diff_out(a2_diff), .diff_valid(a2_dv),
        .sad_out(a2_sad), .sad_valid(a2_sv), .sad_ready(sad_ready), .sample_cnt(a2_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        v0 = 1'b1; reff = 8'd5; data = 8'd2;
        step();
        v0 = 1'b0;
        n_checks++;
        if (a0_diff !== 8'd3 || a0_cnt !== 2'd1) $display("FAIL pre_reset diff=%0d cnt=%0d need 3/1", a0_diff, a0_cnt);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({a0_diff, a0_dv, a0_sad, a0_sv, a0_cnt, a0_rdy} !== '0)
            $display("FAIL async_reset diff=%0d dv=%b sad=%0d sv=%b cnt=%0d rdy=%b need all 0",
                     a0_diff, a0_dv, a0_sad, a0_sv, a0_cnt, a0_rdy);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (a0_rdy !== 1'b1 || a0_cnt !== 2'd0) $display("FAIL reset_release rdy=%b cnt=%0d need 1/0", a0_rdy, a0_cnt);
        else n_pass++;
    endtask

    task automatic test_unsigned_block();
        logic [7:0] rv[4] = '{8'd10, 8'd3, 8'd255, 8'd0};
        logic [7:0] dv[4] = '{8'd3, 8'd10, 8'd0, 8'd0};
        logic [7:0] ex[4] = '{8'd7, 8'd7, 8'd255, 8'd0};
        sad_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; reff = rv[i]; data = dv[i];
            step();
            n_checks++;
            if (a0_diff !== ex[i] || a0_dv !== 1'b1) $display("FAIL u_diff[%0d] diff=%0d dv=%b need %0d/1", i, a0_diff, a0_dv, ex[i]);
            else n_pass++;
            if (i < 3) begin
                n_checks++;
                if (a0_cnt !== 2'(i + 1)) $display("FAIL u_cnt[%0d] cnt=%0d need %0d", i, a0_cnt, i + 1);
                else n_pass++;
            end
        end
        v0 = 1'b0;
        n_checks++;
        if (a0_sad !== 10'd269 || a0_sv !== 1'b1 || a0_rdy !== 1'b0 || a0_cnt !== 2'd0)
            $display("FAIL u_sad sad=%0d sv=%b rdy=%b cnt=%0d need 269/1/0/0", a0_sad, a0_sv, a0_rdy, a0_cnt);
        else n_pass++;
        step();
        n_checks++;
        if (a0_sv !== 1'b0 || a0_rdy !== 1'b1 || a0_dv !== 1'b0)
            $display("FAIL u_release sv=%b rdy=%b dv=%b need 0/1/0", a0_sv, a0_rdy, a0_dv);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] rv[4] = '{8'd10, 8'd3, 8'd255, 8'd0};
        logic [7:0] dv[4] = '{8'd3, 8'd10, 8'd0, 8'd0};
        sad_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; reff = rv[i]; data = dv[i];
            step();
        end
        reff = 8'd1; data = 8'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (a0_sad !== 10'd269 || a0_sv !== 1'b1 || a0_rdy !== 1'b0 || a0_cnt !== 2'd0 || a0_dv !== 1'b0)
                $display("FAIL bp_hold[%0d] sad=%0d sv=%b rdy=%b cnt=%0d dv=%b need 269/1/0/0/0",
                         i, a0_sad, a0_sv, a0_rdy, a0_cnt, a0_dv);
            else n_pass++;
        end
        sad_ready = 1'b1;
        step();
        n_checks++;
        if (a0_sv !== 1'b0 || a0_rdy !== 1'b1 || a0_dv !== 1'b0)
            $display("FAIL bp_release sv=%b rdy=%b dv=%b need 0/1/0", a0_sv, a0_rdy, a0_dv);
        else n_pass++;
        for (int i = 0; i < 4; i++) step();
        v0 = 1'b0;
        n_checks++;
        if (a0_sad !== 10'd4 || a0_sv !== 1'b1) $display("FAIL bp_next_block sad=%0d sv=%b need 4/1", a0_sad, a0_sv);
        else n_pass++;
        step();
    endtask

    task automatic test_signed();
        logic [7:0] rv[4] = '{8'h80, 8'hFF, 8'h05, 8'h00};
        logic [7:0] dv[4] = '{8'h7F, 8'h01, 8'hFB, 8'h00};
        logic [7:0] ex[4] = '{8'd255, 8'd2, 8'd10, 8'd0};
        sad_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1; reff = rv[i]; data = dv[i];
            step();
            n_checks++;
            if (a1_diff !== ex[i] || a1_dv !== 1'b1) $display("FAIL s_diff[%0d] diff=%0d dv=%b need %0d/1", i, a1_diff, a1_dv, ex[i]);
            else n_pass++;
        end
        v1 = 1'b0;
        n_checks++;
        if (a1_sad !== 10'd267 || a1_sv !== 1'b1) $display("FAIL s_sad sad=%0d sv=%b need 267/1", a1_sad, a1_sv);
        else n_pass++;
        step();
    endtask

    task automatic test_clear();
        sad_ready = 1'b1;
        v0 = 1'b1; reff = 8'd0; data = 8'd100;
        step();
        step();
        n_checks++;
        if (a0_cnt !== 2'd2) $display("FAIL clr_pre cnt=%0d need 2", a0_cnt);
        else n_pass++;
        clear = 1'b1; data = 8'd50;
        step();
        clear = 1'b0; v0 = 1'b0;
        n_checks++;
        if (a0_cnt !== 2'd0 || a0_dv !== 1'b0 || a0_diff !== 8'd100)
            $display("FAIL clr_drop cnt=%0d dv=%b diff=%0d need 0/0/100", a0_cnt, a0_dv, a0_diff);
        else n_pass++;
        sad_ready = 1'b0;
        v0 = 1'b1; data = 8'd1;
        for (int i = 0; i < 4; i++) step();
        v0 = 1'b0;
        n_checks++;
        if (a0_sad !== 10'd4 || a0_sv !== 1'b1) $display("FAIL clr_sad sad=%0d sv=%b need 4/1", a0_sad, a0_sv);
        else n_pass++;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (a0_sv !== 1'b0 || a0_rdy !== 1'b1) $display("FAIL clr_hold sv=%b rdy=%b need 0/1", a0_sv, a0_rdy);
        else n_pass++;
        sad_ready = 1'b1;
        step();
    endtask

    task automatic test_max_sum();
        sad_ready = 1'b1;
        reff = 8'd255; data = 8'd0;
        v0 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        v0 = 1'b0;
        n_checks++;
        if (a0_sad !== 10'h3FC || a0_sv !== 1'b1) $display("FAIL max4 sad=%0d sv=%b need 1020/1", a0_sad, a0_sv);
        else n_pass++;
        step();
        v2 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (a2_cnt !== 3'd4 || a2_sv !== 1'b0) $display("FAIL max5_cnt cnt=%0d sv=%b need 4/0", a2_cnt, a2_sv);
        else n_pass++;
        step();
        v2 = 1'b0;
        n_checks++;
        if (a2_sad !== 11'd1275 || a2_sv !== 1'b1 || a2_cnt !== 3'd0)
            $display("FAIL max5 sad=%0d sv=%b cnt=%0d need 1275/1/0", a2_sad, a2_sv, a2_cnt);
        else n_pass++;
        step();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; sad_ready = 1'b1;
        reff = '0; data = '0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_unsigned_block();
        test_backpressure();
        test_signed();
        test_clear();
        test_max_sum();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/abs_diff_sad_acc.md
Name: abs_diff_sad_acc

Overview:
Parametrised, sequential successor to the 8-bit combinational absolute-difference circuit. Accepts a stream of (reff, data) operand pairs over a valid/ready handshake and computes |reff - data| per sample in unsigned or two's-complement mode. Accumulates a sum of absolute differences (SAD) over fixed blocks of BLOCK_LEN samples and holds each block result until the downstream consumer accepts it. Sits between the sample source and the match/decision logic of the block-matching datapath.

Parameters:
WIDTH, 8, operand width in bits (>=2)
BLOCK_LEN, 16, samples per SAD block (>=2, any integer)
SIGNED, 0, 0 = operands unsigned; 1 = operands two's complement
SUM_W, WIDTH+$clog2(BLOCK_LEN), SAD result width (derived; do not override)
CNT_W, $clog2(BLOCK_LEN), sample counter width (derived)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous abort of the current block
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a sample
reff  in  WIDTH  reference operand
data  in  WIDTH  data operand
diff_out  out  WIDTH  registered |reff - data| of the last accepted sample
diff_valid  out  1  one-cycle pulse, diff_out updated
sad_out  out  SUM_W  completed block SAD
sad_valid  out  1  sad_out holds an unconsumed result
sad_ready  in  1  consumer accepts sad_out
sample_cnt  out  CNT_W  samples accepted in the current block

Behaviour:
- Clock: one clock, clk. Reset: asynchronous, active-high, rst. While rst=1, outputs are: diff_out=0, diff_valid=0, sad_out=0, sad_valid=0, sample_cnt=0, internal accumulator=0, state=ACCUM. in_ready=1 from the first edge after rst deasserts.
- Arithmetic: if SIGNED=0, diff = (data>reff) ? data-reff : reff-data. If SIGNED=1, both operands are sign-extended to WIDTH+1 bits before subtracting, and the magnitude is taken. The result is always unsigned WIDTH bits; the maximum is 2^WIDTH-1, so it never overflows.
- Accumulator width is SUM_W. The maximum sum, BLOCK_LEN*(2^WIDTH-1), fits without wrap; overflow is impossible by construction.
- State ACCUM:
  - in_ready=1.
  - An accepted sample is a rising edge with in_valid=1 and in_ready=1. On that edge: diff_out<=diff, diff_valid<=1 (for exactly that one cycle), acc<=acc+diff, sample_cnt<=sample_cnt+1.
  - If the accepted sample is the BLOCK_LEN-th of the block, the same edge also does: sad_out<=acc+diff, sad_valid<=1, acc<=0, sample_cnt<=0, and the state goes to HOLD. Latency from the last sample to sad_valid is 1 edge.
- State HOLD:
  - in_ready=0. in_valid is ignored; no sample is consumed and diff_valid stays 0.
  - sad_out and sad_valid are held stable until sad_ready=1 on a rising edge.
  - On that edge: sad_valid<=0 and the state goes to ACCUM, so in_ready=1 on the next cycle. There is no combinational path from sad_ready to in_ready.
- diff_valid deasserts on any edge where no sample is accepted.
- clear (synchronous, priority over all except rst): acc<=0, sample_cnt<=0, diff_valid<=0, sad_valid<=0, state<=ACCUM. It discards any pending HOLD result. A sample presented in the same cycle as clear is dropped. diff_out and sad_out retain their values (don't-care while not valid).
- rst asserted mid-block or mid-HOLD takes effect immediately (asynchronous) and clears everything listed above.
- sad_ready=1 in ACCUM has no effect.

Test Plan:
1. Reset: assert rst mid-simulation with no clock edge -> all outputs 0 immediately; after release, in_ready=1 and sample_cnt=0.
2. WIDTH=8, BLOCK_LEN=4, SIGNED=0, sad_ready=1: pairs (10,3),(3,10),(255,0),(0,0) on consecutive cycles -> diff_out 7,7,255,0 with diff_valid each cycle; sad_out=269 with sad_valid=1 on the 4th acceptance edge; in_ready=0 one cycle, then 1.
3. Backpressure: as test 2 but with sad_ready=0 for 5 cycles while in_valid=1 (reff=1, data=2) -> sad_out stays 269, in_ready=0, sample_cnt=0, diff_valid=0; raise sad_ready -> sad_valid drops, and the next block starts from acc=0.
4. SIGNED=1, WIDTH=8: (8'h80, 8'h7F) -> diff_out=255; (8'hFF, 8'h01) -> 2; (8'h05, 8'hFB) -> 10; (8'h00, 8'h00) -> 0; sad_out=267.
5. Clear: 2 samples of (0,100), then clear together with sample (0,50) -> sample_cnt=0, (0,50) dropped; a following 4 samples of (0,1) -> sad_out=4. Also assert clear during HOLD -> sad_valid=0 next edge and in_ready=1.
6. Saturation bound: BLOCK_LEN=4, four samples of (255,0) -> sad_out=1020 (10'h3FC) with no wrap. Repeat with BLOCK_LEN=5 -> SUM_W=11 and sad_out=1275.
